// File: rtl/sram22_req_ctrl.sv
// sram22_req_ctrl: request front-end for an SRAM22 single-port macro.
// Turns a valid/ready request stream into per-cycle macro commands. It also
// catches the macro's one-cycle-late read data in a small response FIFO, so
// consumers can stall even though the macro cannot.
module sram22_req_ctrl #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int WMASK_WIDTH = 4,
    parameter int RESP_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [WMASK_WIDTH-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    input  logic [DATA_WIDTH-1:0]  req_din,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_WIDTH-1:0]  resp_data,
    output logic                   sram_we,
    output logic [WMASK_WIDTH-1:0] sram_wmask,
    output logic [ADDR_WIDTH-1:0]  sram_addr,
    output logic [DATA_WIDTH-1:0]  sram_din,
    input  logic [DATA_WIDTH-1:0]  sram_dout,
    output logic                   idle
);

    // Pointer width stays at least one bit so a single-entry FIFO still elaborates.
    localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    // The counter must hold occupancy plus the pending read (up to RESP_DEPTH + 1).
    localparam int CNT_W = $clog2(RESP_DEPTH + 2);

    logic [DATA_WIDTH-1:0] fifo_mem [RESP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      occ;
    logic                  rd_pend;
    logic                  fire;
    logic                  rd_fire;
    logic                  push;
    logic                  pop;

    // Advance a FIFO pointer and wrap it back to zero after the last entry.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit check. Each read fired and not yet popped holds one FIFO slot,
    // whether it sits in the FIFO or is still in the macro's pipeline.
    // req_ready uses registered state only, so it never depends on the payload.
    assign req_ready = (occ + CNT_W'(rd_pend)) < CNT_W'(RESP_DEPTH);

    assign fire    = req_valid & req_ready;
    assign rd_fire = fire & ~req_we;

    // The macro samples these on the same edge the request fires. When the
    // controller is not firing, the macro does a harmless read that is never captured.
    assign sram_addr  = req_addr;
    assign sram_din   = req_din;
    assign sram_we    = fire & req_we;
    assign sram_wmask = (fire & req_we) ? req_wmask : '0;

    // Macro dout is valid exactly one edge after a read fired.
    assign push = rd_pend;
    assign pop  = resp_valid & resp_ready;

    assign resp_valid = (occ != '0);
    assign resp_data  = fifo_mem[rd_ptr];
    assign idle       = (occ == '0) & ~rd_pend;

    // Remember that a read fired, so its data is caught on the next edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            rd_pend <= 1'b0;
        end else begin
            rd_pend <= rd_fire;
        end
    end

    // Response storage. It is cleared on reset so resp_data reads zero while empty.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < RESP_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else if (push) begin
            fifo_mem[wr_ptr] <= sram_dout;
        end
    end

    // Pointer and occupancy bookkeeping. A push and a pop on the same edge
    // leave the occupancy unchanged.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Testbench for sram22_req_ctrl.
// A behavioural macro stands in for the SRAM22. A reference memory plus a queue
// of fired-but-unpopped reads predicts every output each cycle.
module tb_sram22_req_ctrl;

    localparam int DW    = 32;
    localparam int AW    = 11;
    localparam int MW    = 4;
    localparam int DEPTH = 2;

    logic          clk;
    logic          rstb;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [MW-1:0] req_wmask;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_din;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          sram_we;
    logic [MW-1:0] sram_wmask;
    logic [AW-1:0] sram_addr;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic          idle;

    sram22_req_ctrl #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .WMASK_WIDTH(MW),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rstb      (rstb),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_wmask (req_wmask),
        .req_addr  (req_addr),
        .req_din   (req_din),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .sram_we   (sram_we),
        .sram_wmask(sram_wmask),
        .sram_addr (sram_addr),
        .sram_din  (sram_din),
        .sram_dout (sram_dout),
        .idle      (idle)
    );

    typedef struct {
        logic [DW-1:0] data;
        int            edge_n;
    } exp_t;

    logic [DW-1:0] macro_mem [1 << AW];
    logic [DW-1:0] ref_mem   [1 << AW];
    exp_t          exp_q [$];
    int            cyc;
    int            n_checks;
    int            n_pass;
    int            dut_fires;
    bit            rand_done;
    bit            exp_valid;
    bit            exp_fire;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to time when responses should become visible.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SRAM22 macro: registered read, masked write, garbage dout after a write.
    always @(posedge clk) begin
        if (sram_we) begin
            for (int i = 0; i < MW; i++) begin
                if (sram_wmask[i]) macro_mem[sram_addr][8*i +: 8] <= sram_din[8*i +: 8];
            end
            sram_dout <= 32'hDEAD_0BAD;
        end else begin
            sram_dout <= macro_mem[sram_addr];
        end
    end

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
    endtask

    // Monitor: predicts every output from the reference model, then updates the model
    // with the handshakes that happen on the coming edge.
    always @(negedge clk) begin
        if (!rstb) begin
            checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
            checkOutput("rst_resp_data", resp_data, 32'd0);
            checkOutput("rst_idle", 32'(idle), 32'd1);
            checkOutput("rst_sram_we", 32'(sram_we), 32'd0);
            checkOutput("rst_sram_wmask", 32'(sram_wmask), 32'd0);
            exp_q.delete();
        end else begin
            exp_valid = (exp_q.size() > 0) && (exp_q[0].edge_n <= cyc - 1);
            exp_fire  = req_valid && (exp_q.size() < DEPTH);
            checkOutput("req_ready", 32'(req_ready), 32'(exp_q.size() < DEPTH));
            checkOutput("resp_valid", 32'(resp_valid), 32'(exp_valid));
            checkOutput("idle", 32'(idle), 32'(exp_q.size() == 0));
            if (exp_valid) checkOutput("resp_data", resp_data, exp_q[0].data);
            checkOutput("sram_we", 32'(sram_we), 32'(exp_fire && req_we));
            checkOutput("sram_wmask", 32'(sram_wmask), (exp_fire && req_we) ? 32'(req_wmask) : 32'd0);
            if (req_valid && req_ready) dut_fires++;
            if (exp_valid && resp_ready) void'(exp_q.pop_front());
            if (exp_fire) begin
                if (req_we) begin
                    for (int i = 0; i < MW; i++) begin
                        if (req_wmask[i]) ref_mem[req_addr][8*i +: 8] = req_din[8*i +: 8];
                    end
                end else begin
                    exp_q.push_back('{data: ref_mem[req_addr], edge_n: cyc + 1});
                end
            end
        end
    end

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Present one request and hold it until it fires, then return just after that edge.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr,
                                 input logic [DW-1:0] din, input logic [MW-1:0] mask);
        int waited;
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_din   = din;
        req_wmask = mask;
        @(negedge clk);
        while (!req_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        if (!req_ready) begin
            n_checks++;
            $display("[TB] FAIL req_timeout: req_ready still 0 after %0d cycles, expected 1", waited);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    initial begin
        int base;
        n_checks   = 0;
        n_pass     = 0;
        dut_fires  = 0;
        cyc        = 0;
        rand_done  = 1'b0;
        rstb       = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_wmask  = '0;
        req_addr   = '0;
        req_din    = '0;
        resp_ready = 1'b0;
        for (int a = 0; a < (1 << AW); a++) begin
            macro_mem[a] = 32'(a) * 32'h9E37_79B1;
            ref_mem[a]   = 32'(a) * 32'h9E37_79B1;
        end
        idleCycles(3);
        rstb = 1'b1;
        idleCycles(2);

        $display("[TB] basic write/read");
        resp_ready = 1'b1;
        applyStimulus(1'b1, 11'h005, 32'hDEAD_BEEF, 4'hF);
        applyStimulus(1'b0, 11'h005, 32'h0, 4'h0);
        idleCycles(4);

        $display("[TB] partial mask");
        applyStimulus(1'b1, 11'h0FF, 32'h1122_3344, 4'hF);
        applyStimulus(1'b1, 11'h0FF, 32'hAABB_CCDD, 4'b0101);
        applyStimulus(1'b0, 11'h0FF, 32'h0, 4'h0);
        idleCycles(4);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 11'h101, 32'hA, 4'hF);
        applyStimulus(1'b1, 11'h102, 32'hB, 4'hF);
        applyStimulus(1'b1, 11'h103, 32'hC, 4'hF);
        resp_ready = 1'b0;
        base = dut_fires;
        fork
            begin
                applyStimulus(1'b0, 11'h101, 32'h0, 4'h0);
                applyStimulus(1'b0, 11'h102, 32'h0, 4'h0);
                applyStimulus(1'b0, 11'h103, 32'h0, 4'h0);
            end
            begin
                idleCycles(6);
                checkOutput("stall_fires", 32'(dut_fires - base), 32'd2);
                resp_ready = 1'b1;
            end
        join
        idleCycles(5);

        $display("[TB] streaming");
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 11'(i * 3), 32'h0, 4'h0);
        idleCycles(4);

        $display("[TB] mid-flight reset");
        applyStimulus(1'b0, 11'h005, 32'h0, 4'h0);
        rstb = 1'b0;
        idleCycles(2);
        rstb = 1'b1;
        idleCycles(4);

        $display("[TB] write after read");
        applyStimulus(1'b1, 11'h010, 32'h1, 4'hF);
        applyStimulus(1'b0, 11'h010, 32'h0, 4'h0);
        applyStimulus(1'b1, 11'h010, 32'h2, 4'hF);
        applyStimulus(1'b0, 11'h010, 32'h0, 4'h0);
        idleCycles(4);

        $display("[TB] random traffic");
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    applyStimulus(1'($urandom_range(0, 1)), 11'($urandom_range(0, 15)),
                                  $urandom, 4'($urandom_range(0, 15)));
                    if ($urandom_range(0, 4) == 0) idleCycles(1);
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    resp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join

        resp_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() > 0; i++) idleCycles(1);
        checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
        idleCycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
